bcd_counter_2digit: RTL and testbench

- Two-digit BCD up/down counter with a clock prescaler and a digit time-multiplexer.
- Sits directly upstream of the BCD-to-seven-segment decoder. o_bcd feeds the decoder's 4-bit digit input. o_digit_sel drives the common-cathode/anode enable of the active display digit.
- Counts 00..99 with wrap-around. Supports synchronous load and a count-enable.

---
 rtl/bcd_counter_2digit.sv | 116 +++++++++++
 tb/tb_bcd_counter_2digit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_2digit.sv
// Two-digit BCD up/down counter with enable-gated prescaler, synchronous load,
// and a free-running digit multiplexer feeding a seven-segment decoder.
module bcd_counter_2digit #(
  parameter int PRESCALE = 10000,
  parameter int MUX_BITS = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_up,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  output logic [3:0] o_ones,
  output logic [3:0] o_tens,
  output logic [3:0] o_bcd,
  output logic       o_digit_sel,
  output logic       o_tick,
  output logic       o_wrap
);

  localparam logic [15:0]         PS_LAST = 16'(PRESCALE - 1);
  localparam logic [MUX_BITS-1:0] MUX_ONE = MUX_BITS'(1);

  logic [3:0]          ones_q, ones_d;
  logic [3:0]          tens_q, tens_d;
  logic [15:0]         ps_q, ps_d;
  logic [MUX_BITS-1:0] mux_q, mux_d;
  logic                tick_q, tick_d;
  logic                wrap_q, wrap_d;
  logic                step_s;

  // Out-of-range BCD nibbles collapse to 0 so digits stay legal.
  function automatic logic [3:0] bcd_clean(input logic [3:0] n);
    if (n > 4'd9) begin
      return 4'd0;
    end else begin
      return n;
    end
  endfunction

  // Next-state: load beats step; prescaler only moves while enabled.
  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    ps_d   = ps_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    mux_d  = mux_q + MUX_ONE;
    step_s = i_en && (ps_q == PS_LAST);
    if (i_load) begin
      ones_d = bcd_clean(i_load_val[3:0]);
      tens_d = bcd_clean(i_load_val[7:4]);
      ps_d   = 16'd0;
    end else if (step_s) begin
      ps_d   = 16'd0;
      tick_d = 1'b1;
      if (i_up) begin
        if (ones_q == 4'd9) begin
          ones_d = 4'd0;
          if (tens_q == 4'd9) begin
            tens_d = 4'd0;
            wrap_d = 1'b1;
          end else begin
            tens_d = tens_q + 4'd1;
          end
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end else begin
        if (ones_q == 4'd0) begin
          ones_d = 4'd9;
          if (tens_q == 4'd0) begin
            tens_d = 4'd9;
            wrap_d = 1'b1;
          end else begin
            tens_d = tens_q - 4'd1;
          end
        end else begin
          ones_d = ones_q - 4'd1;
        end
      end
    end else if (i_en) begin
      ps_d = ps_q + 16'd1;
    end else begin
      ps_d = ps_q;
    end
  end

  // State registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ones_q <= 4'd0;
      tens_q <= 4'd0;
      ps_q   <= 16'd0;
      mux_q  <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
      ps_q   <= ps_d;
      mux_q  <= mux_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  // Outputs come only from registers; o_bcd is a mux of registered values.
  assign o_ones      = ones_q;
  assign o_tens      = tens_q;
  assign o_digit_sel = mux_q[MUX_BITS-1];
  assign o_bcd       = o_digit_sel ? tens_q : ones_q;
  assign o_tick      = tick_q;
  assign o_wrap      = wrap_q;

endmodule

// File: tb/tb_bcd_counter_2digit.sv
// Directed self-checking bench for bcd_counter_2digit (PRESCALE=4, MUX_BITS=2).
module tb_bcd_counter_2digit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, up = 1'b1, load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [3:0] ones, tens, bcd;
  logic       sel, tick, wrap;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  bcd_counter_2digit #(.PRESCALE(4), .MUX_BITS(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_load(load),
    .i_load_val(load_val), .o_ones(ones), .o_tens(tens), .o_bcd(bcd),
    .o_digit_sel(sel), .o_tick(tick), .o_wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock edge; cyc counts edges since the last reset release (mux model).
  task automatic edge1();
    @(posedge clk);
    if (!rst) cyc++;
    #1;
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) edge1();
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; load_val = v;
    edge1();
    load = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_ones", ones, 4'd0);
    chk("rst_tens", tens, 4'd0);
    chk("rst_bcd", bcd, 4'd0);
    chk("rst_sel", sel, 1'b0);
    chk("rst_tick", tick, 1'b0);
    chk("rst_wrap", wrap, 1'b0);
    edges(2);
    rst = 1'b0; cyc = 0;

    // Basic up count: step every 4 enabled cycles.
    en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      edge1();
      chk($sformatf("up_ones_%0d", k), ones, 32'(k / 4));
      chk($sformatf("up_tick_%0d", k), tick, (k % 4 == 0) ? 1 : 0);
      chk($sformatf("up_wrap_%0d", k), wrap, 1'b0);
    end

    // 98 -> 99 -> 00 (wrap) -> 01.
    do_load(8'h98);
    chk("ld98_tick", tick, 1'b0);
    chk("ld98_val", {tens, ones}, 8'h98);
    edges(4);
    chk("up99_val", {tens, ones}, 8'h99);
    chk("up99_tick", tick, 1'b1);
    chk("up99_wrap", wrap, 1'b0);
    edges(4);
    chk("up00_val", {tens, ones}, 8'h00);
    chk("up00_tick", tick, 1'b1);
    chk("up00_wrap", wrap, 1'b1);
    edge1();
    chk("up00_tick_gone", tick, 1'b0);
    chk("up00_wrap_gone", wrap, 1'b0);
    edges(3);
    chk("up01_val", {tens, ones}, 8'h01);
    chk("up01_wrap", wrap, 1'b0);

    // Down wrap 00 -> 99 -> 98.
    up = 1'b0;
    do_load(8'h00);
    edges(4);
    chk("dn99_val", {tens, ones}, 8'h99);
    chk("dn99_wrap", wrap, 1'b1);
    chk("dn99_tick", tick, 1'b1);
    edges(4);
    chk("dn98_val", {tens, ones}, 8'h98);
    chk("dn98_wrap", wrap, 1'b0);
    do_load(8'h30);
    edges(4);
    chk("dn29_val", {tens, ones}, 8'h29);

    // Invalid nibble sanitising, load with i_en low.
    en = 1'b0; up = 1'b1;
    do_load(8'hA7);
    chk("ldA7_val", {tens, ones}, 8'h07);
    do_load(8'h3F);
    chk("ld3F_val", {tens, ones}, 8'h30);

    // Load coincident with a step cycle wins, no tick; prescaler restarts.
    en = 1'b1;
    edges(3);
    do_load(8'h25);
    chk("ldstep_val", {tens, ones}, 8'h25);
    chk("ldstep_tick", tick, 1'b0);
    edges(3);
    chk("ldstep_hold", {tens, ones}, 8'h25);
    edge1();
    chk("ldstep_next", {tens, ones}, 8'h26);
    chk("ldstep_ntick", tick, 1'b1);

    // Enable gap mid-prescale holds the prescaler at 2.
    do_load(8'h10);
    edges(2);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      edge1();
      chk("gap_val", {tens, ones}, 8'h10);
      chk("gap_tick", tick, 1'b0);
    end
    en = 1'b1;
    edge1();
    chk("gap_pre_val", {tens, ones}, 8'h10);
    chk("gap_pre_tick", tick, 1'b0);
    edge1();
    chk("gap_step_val", {tens, ones}, 8'h11);
    chk("gap_step_tick", tick, 1'b1);

    // Digit multiplexing on a held value of 47.
    en = 1'b0;
    do_load(8'h47);
    for (int k = 0; k < 8; k++) begin
      edge1();
      chk($sformatf("mux_sel_%0d", k), sel, 32'((cyc >> 1) & 1));
      chk($sformatf("mux_bcd_%0d", k), bcd, ((cyc >> 1) & 1) != 0 ? 4 : 7);
    end

    // Asynchronous reset mid-run, with a tick in flight.
    en = 1'b1;
    edges(4);
    chk("pre_rst_tick", tick, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk("arst_ones", ones, 4'd0);
    chk("arst_tens", tens, 4'd0);
    chk("arst_bcd", bcd, 4'd0);
    chk("arst_sel", sel, 1'b0);
    chk("arst_tick", tick, 1'b0);
    chk("arst_wrap", wrap, 1'b0);
    edge1();
    rst = 1'b0; cyc = 0;
    edges(3);
    chk("resume_hold", ones, 4'd0);
    edge1();
    chk("resume_step", ones, 4'd1);
    chk("resume_tick", tick, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
